// File: rtl/pixel_cfg_pkg.sv
// Shared definitions for the pixel-config trigger path: FSM encoding, default widths
// and the minimum pulse spacing.
package pixel_cfg_pkg;

   localparam int DEF_CNT_WIDTH = 32;
   localparam int DEF_NUM_WIDTH = 16;
   localparam int MIN_PERIOD    = 2;

   typedef enum logic [4:0] {
      ST_IDLE   = 5'b00001,
      ST_DELAY  = 5'b00010,
      ST_PULSE  = 5'b00100,
      ST_GAP    = 5'b01000,
      ST_FINISH = 5'b10000
   } train_state_t;

endpackage

// File: rtl/pulse_train_gen_cycle_counter.sv
// Loadable up-counter with synchronous clear/enable and an equality match against a
// terminal value; shared by the DELAY and GAP phases of the train generator.
module cycle_counter
   import pixel_cfg_pkg::*;
#(
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                 clk_in,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 load,
   input  logic [CNT_WIDTH-1:0] load_value,
   input  logic                 enable,
   input  logic [CNT_WIDTH-1:0] terminal,
   output logic                 match
);

   logic [CNT_WIDTH-1:0] count;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable) begin
         count <= count + CNT_WIDTH'(1);
      end
   end

   // Equality only: the owner clears on match, so the count never passes the terminal.
   assign match = (count == terminal);

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable trigger source: after a start, emits N single-cycle pulses, the first
// D cycles after the start edge and then one every max(P, MIN_PERIOD) cycles.
module pulse_train_gen
   import pixel_cfg_pkg::*;
#(
   parameter int CNT_WIDTH = DEF_CNT_WIDTH,
   parameter int NUM_WIDTH = DEF_NUM_WIDTH
) (
   input  logic                 clk_in,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [NUM_WIDTH-1:0] num_pulses,
   input  logic [CNT_WIDTH-1:0] delay,
   input  logic [CNT_WIDTH-1:0] period,
   output logic                 pulse_out,
   output logic                 busy,
   output logic                 done,
   output logic [NUM_WIDTH-1:0] pulse_count
);

   train_state_t state, state_next;

   logic [NUM_WIDTH-1:0] n_q;
   logic [CNT_WIDTH-1:0] d_q;
   logic [CNT_WIDTH-1:0] pe_q;
   logic [CNT_WIDTH-1:0] pe_in;
   logic [CNT_WIDTH-1:0] terminal;
   logic                 match;
   logic                 timing;
   logic                 latch;
   logic                 pulse_next;
   logic                 busy_next;
   logic                 done_next;
   logic [NUM_WIDTH-1:0] count_next;

   assign pe_in  = (period < CNT_WIDTH'(MIN_PERIOD)) ? CNT_WIDTH'(MIN_PERIOD) : period;
   assign timing = (state == ST_DELAY) || (state == ST_GAP);

   // DELAY spans D cycles, GAP spans Pe-1 cycles; the counter starts from zero in both.
   assign terminal = (state == ST_DELAY) ? (d_q - CNT_WIDTH'(1)) : (pe_q - CNT_WIDTH'(2));

   cycle_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_counter (
      .clk_in     (clk_in),
      .rst        (rst),
      .clear      (!timing || match || abort),
      .load       (1'b0),
      .load_value ('0),
      .enable     (timing),
      .terminal   (terminal),
      .match      (match)
   );

   always_comb begin
      state_next = state;
      latch      = 1'b0;
      done_next  = 1'b0;
      count_next = pulse_count;
      unique case (state)
         ST_IDLE: begin
            if (start && !abort) begin
               count_next = '0;
               if (num_pulses == '0) begin
                  done_next = 1'b1;
               end else begin
                  latch = 1'b1;
                  if (delay == '0) begin
                     state_next = ST_PULSE;
                     count_next = NUM_WIDTH'(1);
                  end else begin
                     state_next = ST_DELAY;
                  end
               end
            end
         end
         ST_DELAY, ST_GAP: begin
            if (abort) begin
               state_next = ST_IDLE;
            end else if (match) begin
               state_next = ST_PULSE;
               count_next = pulse_count + NUM_WIDTH'(1);
            end
         end
         ST_PULSE: begin
            if (abort) begin
               state_next = ST_IDLE;
            end else if (pulse_count == n_q) begin
               state_next = ST_FINISH;
            end else begin
               state_next = ST_GAP;
            end
         end
         ST_FINISH: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      // Outputs are registered from the next state so they line up with it.
      pulse_next = (state_next == ST_PULSE);
      busy_next  = (state_next == ST_DELAY) || (state_next == ST_PULSE) ||
                   (state_next == ST_GAP);
      done_next  = done_next || (state_next == ST_FINISH);
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         pulse_out   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pulse_count <= '0;
      end else begin
         state       <= state_next;
         pulse_out   <= pulse_next;
         busy        <= busy_next;
         done        <= done_next;
         pulse_count <= count_next;
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         n_q  <= '0;
         d_q  <= '0;
         pe_q <= '0;
      end else if (latch) begin
         n_q  <= num_pulses;
         d_q  <= delay;
         pe_q <= pe_in;
      end
   end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: per-cycle traces of pulse_out/busy/done are
// captured as bitmaps (bit k = cycle t0+k) and compared with hand-derived values.
module tb_pulse_train_gen;

   logic        clk_in = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [15:0] num_pulses;
   logic [31:0] delay;
   logic [31:0] period;
   logic        pulse_out;
   logic        busy;
   logic        done;
   logic [15:0] pulse_count;

   int checks = 0;
   int failures = 0;

   logic [63:0] pt, bt, dt;

   always #5 clk_in = ~clk_in;

   pulse_train_gen dut (
      .clk_in      (clk_in),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .num_pulses  (num_pulses),
      .delay       (delay),
      .period      (period),
      .pulse_out   (pulse_out),
      .busy        (busy),
      .done        (done),
      .pulse_count (pulse_count)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Start edge t0 is the rising edge after setup; sample c is taken in cycle t0+c.
   task automatic run_train(input logic [15:0] n, input logic [31:0] d, input logic [31:0] p,
                            input int ncyc, input int abort_cyc, input bit hold_start,
                            input int pchg_cyc,
                            output logic [63:0] tp, output logic [63:0] tb,
                            output logic [63:0] td);
      tp = '0;
      tb = '0;
      td = '0;
      @(negedge clk_in);
      num_pulses = n;
      delay      = d;
      period     = p;
      start      = 1'b1;
      abort      = (abort_cyc == 0);
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk_in);
         tp[c] = pulse_out;
         tb[c] = busy;
         td[c] = done;
         if (!hold_start) start = 1'b0;
         abort = (c == abort_cyc);
         if (c == pchg_cyc) period = p + 32'd7;
         if (c == pchg_cyc + 3) period = p;
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic go_idle();
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk_in);
      abort = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      num_pulses = '0;
      delay      = '0;
      period     = '0;
      repeat (3) @(negedge clk_in);
      check_eq("reset_outputs", {45'd0, pulse_out, busy, done, pulse_count}, 64'd0);
      rst = 1'b0;

      // D=3 P=5 N=3
      run_train(16'd3, 32'd3, 32'd5, 20, -1, 1'b0, 0, pt, bt, dt);
      check_eq("s1_pulse", pt, 64'h4210);
      check_eq("s1_busy",  bt, 64'h7FFE);
      check_eq("s1_done",  dt, 64'h8000);
      check_eq("s1_count", 64'(pulse_count), 64'd3);

      // D=0, P=1 clamped to 2, N=4
      run_train(16'd4, 32'd0, 32'd1, 10, -1, 1'b0, 0, pt, bt, dt);
      check_eq("s2_pulse", pt, 64'hAA);
      check_eq("s2_busy",  bt, 64'hFE);
      check_eq("s2_done",  dt, 64'h100);
      check_eq("s2_count", 64'(pulse_count), 64'd4);

      // N=0: immediate done, no train
      run_train(16'd0, 32'd3, 32'd5, 4, -1, 1'b0, 0, pt, bt, dt);
      check_eq("s3_pulse", pt, 64'h0);
      check_eq("s3_busy",  bt, 64'h0);
      check_eq("s3_done",  dt, 64'h2);
      check_eq("s3_count", 64'(pulse_count), 64'd0);

      // D=2 P=10 N=5, abort in cycle 15
      run_train(16'd5, 32'd2, 32'd10, 20, 15, 1'b0, 0, pt, bt, dt);
      check_eq("s4_pulse", pt, 64'h2008);
      check_eq("s4_busy",  bt, 64'hFFFE);
      check_eq("s4_done",  dt, 64'h0);
      check_eq("s4_count", 64'(pulse_count), 64'd2);

      // abort together with start in IDLE: nothing starts, count holds
      run_train(16'd2, 32'd1, 32'd3, 5, 0, 1'b0, 0, pt, bt, dt);
      check_eq("abort_start_pulse", pt, 64'h0);
      check_eq("abort_start_busy",  bt, 64'h0);
      check_eq("abort_start_done",  dt, 64'h0);
      check_eq("abort_start_count", 64'(pulse_count), 64'd2);

      // start held high, D=1 P=3 N=2, period disturbed mid-train
      run_train(16'd2, 32'd1, 32'd3, 15, -1, 1'b1, 3, pt, bt, dt);
      check_eq("s5_pulse", pt, 64'h1224);
      check_eq("s5_busy",  bt, 64'h9F3E);
      check_eq("s5_done",  dt, 64'h2040);
      go_idle();
      @(negedge clk_in);
      check_eq("s5_abort_idle", {61'd0, pulse_out, busy, done}, 64'd0);

      // async reset during GAP (cycle 6 of a D=3 P=5 N=3 train)
      @(negedge clk_in);
      num_pulses = 16'd3;
      delay      = 32'd3;
      period     = 32'd5;
      start      = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk_in);
         start = 1'b0;
      end
      check_eq("s6_busy_before", 64'(busy), 64'd1);
      check_eq("s6_count_before", 64'(pulse_count), 64'd1);
      #2 rst = 1'b1;
      #1;
      check_eq("s6_async_reset", {45'd0, pulse_out, busy, done, pulse_count}, 64'd0);
      @(negedge clk_in);
      rst = 1'b0;
      run_train(16'd3, 32'd3, 32'd5, 20, -1, 1'b0, 0, pt, bt, dt);
      check_eq("s6_pulse", pt, 64'h4210);
      check_eq("s6_busy",  bt, 64'h7FFE);
      check_eq("s6_done",  dt, 64'h8000);
      check_eq("s6_count", 64'(pulse_count), 64'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- Programmable trigger source that sits directly upstream of the pixel-config pulse stretcher.
- On a start request it emits N single-cycle pulses on pulse_out, after an initial delay of D cycles and with a rising-edge-to-rising-edge spacing of P cycles.
- pulse_out connects to the stretcher's pulse_in. busy, done and pulse_count are status outputs for the control-register block.

Parameters:
- CNT_WIDTH, 32, width of the delay and period fields and of the internal cycle counter.
- NUM_WIDTH, 16, width of num_pulses and pulse_count.
- MIN_PERIOD, 2, smallest period used; a programmed period below this is clamped to it.

Ports:
- clk_in  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  level, sampled only in IDLE; launches a train.
- abort  in  1  synchronous cancel of a running train.
- num_pulses  in  NUM_WIDTH  pulse count N, latched at start.
- delay  in  CNT_WIDTH  cycles D from start sample to first pulse, latched at start.
- period  in  CNT_WIDTH  spacing P between pulses, latched at start.
- pulse_out  out  1  registered single-cycle pulses.
- busy  out  1  high while a train is in progress.
- done  out  1  one-cycle completion strobe.
- pulse_count  out  NUM_WIDTH  pulses emitted in the current or last train.

Behaviour:
- Reset: pulse_out=0, busy=0, done=0, pulse_count=0, state=IDLE, shadow registers=0. Reset asserted mid-train discards the train immediately, with no done.
- All outputs are registered.
- Shadow registers: N, D and P are latched at the start edge. Input changes during a train have no effect.
- Effective period Pe = max(P, MIN_PERIOD).
- States:
  - IDLE: on start=1 with N!=0, latch inputs, clear pulse_count, go to DELAY (or PULSE if D=0). On start=1 with N=0, assert done for one cycle, stay IDLE, pulse_count=0.
  - DELAY: counter counts D cycles, then PULSE.
  - PULSE: pulse_out=1 for one cycle, pulse_count increments. If pulse_count reaches N, go to FINISH; otherwise go to GAP.
  - GAP: counter counts Pe-1 low cycles, then PULSE.
  - FINISH: done=1 for one cycle, busy=0, then IDLE.
- Timing: start sampled at edge t0 gives busy=1 from cycle t0+1.
  - Pulse k (k=0..N-1) is high in cycle t0+1+D+k*Pe.
  - done is high in cycle t0+2+D+(N-1)*Pe. busy is low in that same cycle.
- start while busy is ignored, including in the FINISH cycle. A new train can be accepted in the cycle after done.
- abort=1 in any non-IDLE state: the next edge gives IDLE, pulse_out=0, busy=0, no done; pulse_count holds its value.
  - abort coincident with a PULSE cycle: that pulse still completes, since it is already registered.
  - abort together with start in IDLE: abort wins and no train starts.
- The counter is CNT_WIDTH wide with no wrap. D = 2^CNT_WIDTH-1 is legal. The counter compares for equality and never overflows.
- pulse_count saturates at N and holds after done until the next accepted start.

Decomposition:
- Shared package pixel_cfg_pkg holds:
  - the state encoding (one-hot, 5 states);
  - MIN_PERIOD;
  - the default widths CNT_WIDTH and NUM_WIDTH.
- One natural sub-module, cycle_counter: a loadable CNT_WIDTH up-counter with clear, enable and a terminal-match output. It is reused for the DELAY and GAP phases.

Test Plan:
- D=3, P=5, N=3, start at t0=0 -> pulse_out high in cycles 4, 9, 14 only; done in cycle 15; busy high in cycles 1..14; pulse_count=3.
- D=0, P=1 (clamped to 2), N=4 -> pulses in cycles 1, 3, 5, 7; done in cycle 8.
- N=0 with start -> done high one cycle after the start edge; busy never high; pulse_out stays 0.
- D=2, P=10, N=5, abort asserted in cycle 15 -> pulses in cycles 3 and 13 only; busy drops after the next edge; no done; pulse_count=2.
- start held high throughout with D=1, P=3, N=2 -> pulses in cycles 2 and 5; done in cycle 6; second train's first pulse in cycle 9. Also, changing period mid-train has no effect.
- rst asserted asynchronously during GAP -> all outputs 0 immediately. After release, the first start behaves exactly as in the first scenario.
